// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring
// shift-subtract step per clock, with signs resolved at latch time and fixed up on completion.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic              neg_res;
  logic              rem_neg;

  logic              is_div;
  logic              sign_a;
  logic              sign_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              b_zero;
  logic              ovf;
  logic              special;
  logic [XLEN-1:0]   special_val;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [XLEN-1:0]   hi_next;
  logic [XLEN-1:0]   lo_next;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   final_val;

  // Operand decode: MUL is treated as signed since its low half is sign-agnostic.
  always_comb begin
    is_div  = Op[2];
    sign_a  = !Op[0] || (Op == 3'd1);
    sign_b  = (Op[2] && !Op[0]) || (Op[2:1] == 2'b00);
    a_neg   = sign_a && SrcA[XLEN-1];
    b_neg   = sign_b && SrcB[XLEN-1];
    a_abs   = a_neg ? -SrcA : SrcA;
    b_abs   = b_neg ? -SrcB : SrcB;
    b_zero  = (SrcB == '0);
    ovf     = is_div && !Op[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    special = is_div && (b_zero || ovf);
    if (b_zero) special_val = Op[1] ? SrcA : '1;
    else        special_val = Op[1] ? '0 : SrcA;
  end

  // Shared datapath: hi/lo hold the running product, or remainder/quotient when dividing.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    div_sub   = div_shift[XLEN-1:0] - b_mag;
    if (op_q[2]) begin
      hi_next = div_ge ? div_sub : div_shift[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod     = {hi_next, lo_next};
    prod_fix = neg_res ? -prod : prod;
    q_fix    = neg_res ? -lo_next : lo_next;
    r_fix    = rem_neg ? -hi_next : hi_next;
    case (op_q)
      3'd0:          final_val = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          final_val = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    final_val = q_fix;
      default:       final_val = r_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_res <= 1'b0;
      rem_neg <= 1'b0;
      Result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op_q    <= Op;
            a_mag   <= a_abs;
            b_mag   <= b_abs;
            hi      <= '0;
            lo      <= is_div ? a_abs : b_abs;
            neg_res <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            count   <= '0;
            if (special) begin
              Result <= special_val;
              state  <= FINISH;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          hi    <= hi_next;
          lo    <= lo_next;
          count <= count + 1'b1;
          // The last step writes the sign-corrected result so it is valid throughout FINISH.
          if (count == CW'(XLEN-1)) begin
            Result <= final_val;
            state  <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == FINISH);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .Op     (Op),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built directly from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic [63:0]        p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Runs one operation; optionally pokes Start mid-calculation and in the FINISH cycle.
  task automatic apply_stimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                                input int poke_cycle, input bit poke_finish);
    int          lat;
    logic        busy_ok;
    logic [31:0] res;
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    Start = 1'b1;
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) Start = 1'b0;
      if (n == poke_cycle) begin
        Start = 1'b1;
        Op    = 3'($urandom_range(0, 7));
        SrcA  = $urandom;
        SrcB  = $urandom;
      end else if (n == poke_cycle + 1) begin
        Start = 1'b0;
      end
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        lat = n;
        break;
      end
    end
    res = Result;
    check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    check_output({tag, "_result"}, res, exp_res);
    if (poke_finish) begin
      Start = 1'b1;
      Op    = 3'd0;
      SrcA  = 32'd9;
      SrcB  = 32'd9;
      @(negedge clk);
      Start = 1'b0;
      check_output({tag, "_finish_start_busy"}, {31'b0, Busy}, 32'd0);
      check_output({tag, "_finish_start_done"}, {31'b0, Done}, 32'd0);
      check_output({tag, "_finish_start_result"}, Result, res);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0;
    Start = 1'b0;
    Op    = 3'd0;
    SrcA  = 32'd0;
    SrcB  = 32'd0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", {31'b0, Busy}, 32'd0);
    check_output("reset_done", {31'b0, Done}, 32'd0);
    check_output("reset_result", Result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    apply_stimulus("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 1'b0);
    apply_stimulus("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0, 1'b0);
    apply_stimulus("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0, 1'b0);
    apply_stimulus("mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 1'b0);
    apply_stimulus("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 1'b0);
    apply_stimulus("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 1'b0);
    apply_stimulus("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0, 1'b0);
    apply_stimulus("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33, 0, 1'b0);
    apply_stimulus("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    apply_stimulus("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1, 0, 1'b0);
    apply_stimulus("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
    apply_stimulus("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 1'b0);
    apply_stimulus("mul_ignored_start", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 10, 1'b1);

    $display("[TB] reset during divide");
    @(negedge clk);
    Start = 1'b1;
    Op    = 3'd4;
    SrcA  = 32'd1000;
    SrcB  = 32'd3;
    @(posedge clk);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) Start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_output("midreset_busy", {31'b0, Busy}, 32'd0);
    check_output("midreset_done", {31'b0, Done}, 32'd0);
    check_output("midreset_result", Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("mul_after_reset", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0, 1'b0);

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      apply_stimulus($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b),
                     model_latency(op, a, b), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
